// File: rtl/fp_arb_pkg.sv
// fp_arb_pkg: shared widths, operand/stage record types and small helpers
// used by the floating-point adder arbiter and its datapath.
package fp_arb_pkg;

  localparam int FP_W     = 32;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  // Widest requester index the arbiter supports (up to 8 requesters).
  localparam int MAX_ID_W = 3;

  // IEEE-754 single-precision field view.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_t;

  // Contents of the operand stage: one request waiting for the adder.
  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
    fp_t                 a;
    fp_t                 b;
  } stage_t;

  // Index of the set bit in a one-hot (or zero) vector; zero maps to 0.
  function automatic logic [MAX_ID_W-1:0] onehot_to_idx(input logic [7:0] onehot);
    logic [MAX_ID_W-1:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) begin
        idx = idx | 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/fp_adder.sv
// fp_adder: combinational IEEE-754 single-precision adder, round to nearest
// even. Handles zeros, subnormals, infinities and NaNs; exact cancellation
// yields +0 unless both operands are negative.
module fp_adder
  import fp_arb_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] out
);

  // Working significand layout: [27] carry, [26] hidden bit, [25:3] fraction,
  // [2] guard, [1] round, [0] sticky.
  function automatic logic [FP_W-1:0] fp_add(input fp_t a_in, input fp_t b_in);
    fp_t              x;
    fp_t              y;
    logic [EXP_W-1:0] ex;
    logic [EXP_W-1:0] ey;
    logic [EXP_W-1:0] d;
    logic [27:0]      ax;
    logic [27:0]      ay;
    logic [27:0]      w;
    logic [9:0]       e;
    logic [24:0]      mr;
    logic             rnd;
    logic [FP_W-1:0]  res;

    // Order by magnitude so the larger operand sets sign and exponent.
    if ({a_in.exp, a_in.man} >= {b_in.exp, b_in.man}) begin
      x = a_in;
      y = b_in;
    end else begin
      x = b_in;
      y = a_in;
    end

    // Subnormals share the minimum exponent with no hidden bit.
    ex = (x.exp == 8'd0) ? 8'd1 : x.exp;
    ey = (y.exp == 8'd0) ? 8'd1 : y.exp;
    d  = ex - ey;
    ax = {1'b0, (x.exp != 8'd0), x.man, 3'b000};
    ay = {1'b0, (y.exp != 8'd0), y.man, 3'b000};

    // Align the smaller operand, folding shifted-out bits into sticky.
    if (d > 8'd26) begin
      ay = {27'd0, |ay};
    end else begin
      ay = (ay >> d) | {27'd0, |(ay & ((28'd1 << d) - 28'd1))};
    end

    if (x.sign == y.sign) begin
      w = ax + ay;
    end else begin
      w = ax - ay;
    end

    e   = {2'b00, ex};
    res = 32'h0000_0000;
    mr  = 25'd0;
    rnd = 1'b0;

    if (x.exp == 8'hFF) begin
      if (x.man != 23'd0) begin
        res = {x.sign, 8'hFF, 1'b1, x.man[21:0]};
      end else if ((y.exp == 8'hFF) && (x.sign != y.sign)) begin
        res = 32'h7FC0_0000;
      end else begin
        res = x;
      end
    end else if (w == 28'd0) begin
      res = {x.sign & y.sign, 31'd0};
    end else begin
      if (w[27]) begin
        w = {1'b0, w[27:2], w[1] | w[0]};
        e = e + 10'd1;
      end else begin
        for (int i = 0; i < 26; i++) begin
          if (!w[26] && (e > 10'd1)) begin
            w = w << 1;
            e = e - 10'd1;
          end else begin
            w = w;
          end
        end
      end

      rnd = w[2] & (w[1] | w[0] | w[3]);
      mr  = {1'b0, w[26:3]} + {24'd0, rnd};
      if (mr[24]) begin
        mr = {1'b0, mr[24:1]};
        e  = e + 10'd1;
      end else begin
        mr = mr;
      end

      if (e >= 10'd255) begin
        res = {x.sign, 8'hFF, 23'd0};
      end else begin
        res = {x.sign, (mr[23] ? e[7:0] : 8'd0), mr[22:0]};
      end
    end
    return res;
  endfunction

  // Purely combinational sum of the two operands.
  always_comb begin
    out = fp_add(a, b);
  end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter. Priority starts one past the last
// requester whose transfer was accepted; a stalled grant stays put because
// the pointer only moves when 'advance' reports an accepted transfer.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int              PTR_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(N - 1);

  logic [PTR_W-1:0] last_grant_r;
  logic [PTR_W-1:0] grant_idx_s;
  logic             found_s;

  // Rotating search for the first asserted request after last_grant.
  always_comb begin
    grant       = {N{1'b0}};
    grant_idx_s = last_grant_r;
    found_s     = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found_s && req[(int'(last_grant_r) + k) % N]) begin
        grant[(int'(last_grant_r) + k) % N] = 1'b1;
        grant_idx_s = PTR_W'((int'(last_grant_r) + k) % N);
        found_s     = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Remember the winner only once its transfer has actually happened.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= PTR_INIT;
    end else if (advance && found_s) begin
      last_grant_r <= grant_idx_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: shares one combinational fp_adder among NUM_REQ
// requesters. A round-robin grant feeds an operand stage (S1); the adder sits
// between S1 and the result stage (S2), which drives the tagged response.
module fp_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [FP_W-1:0]         rsp_sum
);

  logic [NUM_REQ-1:0]  grant_s;
  logic [7:0]          grant_ext_s;
  logic [MAX_ID_W-1:0] gidx_s;
  fp_t                 a_sel_s;
  fp_t                 b_sel_s;
  logic                s2_load_s;
  logic                s1_free_s;
  logic                accept_s;
  logic [FP_W-1:0]     sum_s;

  stage_t              s1_r;
  logic                s2_valid_r;
  logic [MAX_ID_W-1:0] s2_id_r;
  logic [FP_W-1:0]     s2_sum_r;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .advance(accept_s),
    .grant  (grant_s)
  );

  // Operand selection and pipeline advance/handshake decisions.
  always_comb begin
    grant_ext_s                = 8'd0;
    grant_ext_s[NUM_REQ-1:0]   = grant_s;
    gidx_s                     = onehot_to_idx(grant_ext_s);
    a_sel_s                    = req_a[FP_W*int'(gidx_s) +: FP_W];
    b_sel_s                    = req_b[FP_W*int'(gidx_s) +: FP_W];
    s2_load_s                  = s1_r.valid && (!s2_valid_r || rsp_ready);
    s1_free_s                  = !s1_r.valid || s2_load_s;
    req_ready                  = grant_s & {NUM_REQ{s1_free_s}};
    accept_s                   = |req_ready;
  end

  // Operand stage: capture an accepted request, empty once S2 takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= {$bits(stage_t){1'b0}};
    end else if (accept_s) begin
      s1_r.valid <= 1'b1;
      s1_r.id    <= gidx_s;
      s1_r.a     <= a_sel_s;
      s1_r.b     <= b_sel_s;
    end else if (s2_load_s) begin
      s1_r.valid <= 1'b0;
    end else begin
      s1_r <= s1_r;
    end
  end

  fp_adder u_add (
    .a  (s1_r.a),
    .b  (s1_r.b),
    .out(sum_s)
  );

  // Result stage: load the sum when free or draining, hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_id_r    <= 3'd0;
      s2_sum_r   <= 32'h0000_0000;
    end else if (s2_load_s) begin
      s2_valid_r <= 1'b1;
      s2_id_r    <= s1_r.id;
      s2_sum_r   <= sum_s;
    end else if (rsp_ready) begin
      s2_valid_r <= 1'b0;
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

  assign rsp_valid = s2_valid_r;
  assign rsp_id    = ID_W'(s2_id_r);
  assign rsp_sum   = s2_sum_r;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: directed bench. A transaction-level model (round-robin
// pointer, in-flight queue with accept times, capacity of two) predicts
// req_ready and the response every cycle; literal checks pin key scenarios.
module tb_fp_add_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [31:0]     rsp_sum;

  fp_add_arbiter #(.NUM_REQ(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_sum  (rsp_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    int          id;
    logic [31:0] sum;
    int          acc;
  } item_t;

  item_t       q[$];
  logic [31:0] exp_sum [N];
  int          ptr;
  int          ecnt;
  logic [N-1:0] m_ready;
  logic        m_rvalid;
  int          m_gid;

  task automatic model_reset();
    q.delete();
    ptr  = N - 1;
    ecnt = 0;
  endtask

  // Predict this cycle's outputs and compare against the DUT.
  task automatic compare_model();
    logic room;
    m_gid = -1;
    for (int k = 1; k <= N; k++) begin
      if (m_gid < 0 && req_valid[(ptr + k) % N]) m_gid = (ptr + k) % N;
    end
    m_rvalid = 1'b0;
    if (q.size() > 0) m_rvalid = (ecnt >= q[0].acc + 1);
    room    = (q.size() < 2) || (rsp_ready && m_rvalid);
    m_ready = '0;
    if (room && m_gid >= 0) m_ready[m_gid] = 1'b1;
    if (!rst_n) begin
      m_ready  = '0;
      m_rvalid = 1'b0;
    end
    check("model req_ready", 32'(req_ready), 32'(m_ready));
    check("model rsp_valid", 32'(rsp_valid), 32'(m_rvalid));
    if (m_rvalid) begin
      check("model rsp_id", 32'(rsp_id), 32'(q[0].id));
      check("model rsp_sum", rsp_sum, q[0].sum);
    end
  endtask

  // Apply one clock edge to the model.
  task automatic apply_model_edge();
    if (rst_n) begin
      ecnt++;
      if (m_rvalid && rsp_ready) void'(q.pop_front());
      if (m_ready != '0) begin
        q.push_back('{m_gid, exp_sum[m_gid], ecnt});
        ptr = m_gid;
      end
    end
  endtask

  // One clock cycle: compare mid-cycle, then step through the rising edge.
  task automatic cyc();
    #2;
    compare_model();
    @(posedge clk);
    apply_model_edge();
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] s);
    req_valid[i]      = 1'b1;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    exp_sum[i]        = s;
  endtask

  int grant_ord [6] = '{1, 2, 4, 8, 1, 2};
  int id_ord    [6] = '{0, 1, 2, 3, 0, 1};
  int cnt;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) exp_sum[i] = 32'h0;
    model_reset();

    // Reset state
    repeat (3) cyc();
    check("reset rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset rsp_id", 32'(rsp_id), 32'h0);
    check("reset rsp_sum", rsp_sum, 32'h0);
    check("reset req_ready", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    cyc();
    check("post-reset rsp_valid", 32'(rsp_valid), 32'h0);
    check("post-reset req_ready", 32'(req_ready), 32'h0);

    // Single op: 1.5 + 2.5 = 4.0, two cycles of latency
    rsp_ready = 1'b1;
    set_req(0, 32'h3FC0_0000, 32'h4020_0000, 32'h4080_0000);
    #1 check("single grant", 32'(req_ready), 32'h1);
    cyc();
    req_valid[0] = 1'b0;
    cyc();
    check("single rsp_valid", 32'(rsp_valid), 32'h1);
    check("single rsp_id", 32'(rsp_id), 32'h0);
    check("single rsp_sum", rsp_sum, 32'h4080_0000);
    repeat (2) cyc();

    // Fairness: restart the pointer, then hold all four requesters valid
    rst_n = 1'b0;
    model_reset();
    #1 rst_n = 1'b1;
    set_req(0, 32'h3FC0_0000, 32'h4020_0000, 32'h4080_0000);
    set_req(1, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
    set_req(2, 32'h4000_0000, 32'h3F80_0000, 32'h4040_0000);
    set_req(3, 32'h3F80_0000, 32'h3F00_0000, 32'h3FC0_0000);
    for (int k = 0; k < 8; k++) begin
      if (k == 6) req_valid = '0;
      #1;
      if (k < 6) check("fair grant", 32'(req_ready), 32'(grant_ord[k]));
      if (k >= 2) begin
        check("fair rsp_valid", 32'(rsp_valid), 32'h1);
        check("fair rsp_id", 32'(rsp_id), 32'(id_ord[k-2]));
      end
      cyc();
    end

    // Backpressure: five stalled cycles with req2 streaming 1.0 + 1.0
    rsp_ready = 1'b0;
    set_req(2, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (req_ready[2]) cnt++;
      cyc();
    end
    check("bp accepts", 32'(cnt), 32'd2);
    #1 check("bp stalled ready", 32'(req_ready), 32'h0);
    rsp_ready = 1'b1;
    cnt = 0;
    #1 check("drain and fill ready", 32'(req_ready), 32'h4);
    if (rsp_valid && rsp_id == 2'd2 && rsp_sum == 32'h4000_0000) cnt++;
    cyc();
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (rsp_valid && rsp_id == 2'd2 && rsp_sum == 32'h4000_0000) cnt++;
      cyc();
    end
    check("bp results delivered", 32'(cnt), 32'd3);

    // Cancellation: x + (-x) = +0 for requester 1
    set_req(1, 32'hC618_CAAE, 32'h4618_CAAE, 32'h0000_0000);
    #1 check("cancel grant", 32'(req_ready), 32'h2);
    cyc();
    req_valid[1] = 1'b0;
    cyc();
    check("cancel rsp_valid", 32'(rsp_valid), 32'h1);
    check("cancel rsp_id", 32'(rsp_id), 32'h1);
    check("cancel rsp_sum", rsp_sum, 32'h0);
    repeat (2) cyc();

    // Reset mid-flight with both stages occupied
    rsp_ready = 1'b0;
    set_req(3, 32'h4000_0000, 32'h3F80_0000, 32'h4040_0000);
    repeat (3) cyc();
    check("flight rsp_valid", 32'(rsp_valid), 32'h1);
    check("flight full ready", 32'(req_ready), 32'h0);
    rst_n     = 1'b0;
    req_valid = '0;
    model_reset();
    #1 check("mid-reset rsp_valid", 32'(rsp_valid), 32'h0);
    repeat (2) cyc();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (rsp_valid) cnt++;
      cyc();
    end
    check("no stale rsp", 32'(cnt), 32'd0);
    set_req(0, 32'h3F80_0000, 32'h3F00_0000, 32'h3FC0_0000);
    req_valid[3] = 1'b1;
    #1 check("post-reset grant", 32'(req_ready), 32'h1);
    cyc();
    cyc();
    req_valid = '0;
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_add_arbiter.md
# fp_add_arbiter

Shares one combinational `fp_adder` (IEEE-754 single precision, `a + b -> out`) among `NUM_REQ` requesters. It uses round-robin arbitration, a two-stage registered pipeline and a single tagged response channel. The block sits between the requesting units and the shared adder: it sequences operand delivery, captures the sum and returns it with the requester's index.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester index (derived; do not override).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`: per-requester operand valid.
- `req_ready`  out  `NUM_REQ`: per-requester accept; one-hot or zero.
- `req_a`  in  `NUM_REQ*32`: operand A, requester i at `[32*i +: 32]`.
- `req_b`  in  `NUM_REQ*32`: operand B, same packing.
- `rsp_valid`  out  1: result valid.
- `rsp_ready`  in  1: consumer accepts result.
- `rsp_id`  out  `ID_W`: index of the requester that owns `rsp_sum`.
- `rsp_sum`  out  32: `a + b` as produced by `fp_adder`.

## Operation
- **Handshake.** A transfer occurs on any edge where valid && ready.
  - Requesters hold `req_valid`, `req_a` and `req_b` stable until accepted.
  - `req_ready` may depend combinationally on `req_valid`.
  - Requesters must not make `req_valid` depend on `req_ready`.
- **Arbitration.** Round-robin over asserted `req_valid` bits.
  - Search starts at `last_grant+1` (mod `NUM_REQ`).
  - `last_grant` updates only on an accepted transfer.
  - A granted-but-stalled requester keeps its grant; the pointer does not move.
- **Stage 1 (S1).** Registers operands A and B, the requester id and `s1_valid`.
- **Stage 2 (S2).** Registers `fp_adder(S1.a, S1.b)`, the id and `s2_valid`. S2 drives `rsp_*`.
- **Advance rules:**
  - `s2_load = s1_valid && (!s2_valid || rsp_ready)`.
  - `s1_free = !s1_valid || s2_load`.
  - `req_ready[g] = s1_free && grant[g]`.
- **Valid updates:**
  - `s2_valid` is set by `s2_load`; it is cleared by `rsp_ready && !s2_load`.
  - `s1_valid` is set on accept; it is cleared by `s2_load` with no new accept.
- Data is passed through unmodified. All special cases (zero, cancellation, sign) are owned by `fp_adder`.

## Timing
- **Reset values:**
  - `req_ready = 0`, `rsp_valid = 0`.
  - `rsp_id = 0`, `rsp_sum = 32'h0`.
  - `s1_valid = s2_valid = 0`.
  - `last_grant = NUM_REQ-1`, so the first grant goes to requester 0.
- **Latency.** A request accepted at edge N presents `rsp_valid` after edge N+1 (2 cycles). This holds when there is no backpressure.
- **Throughput.** One result per cycle while `rsp_ready=1`.
- **Full backpressure.** With `rsp_ready=0` and both stages valid, `req_ready` is all-zero and nothing is lost or overwritten.
- **Simultaneous drain and fill.** When `rsp_ready=1` with both stages full, S2 takes S1 and S1 accepts a new request in the same cycle.
- **Single requester.** A lone asserted requester is granted every cycle regardless of pointer position.
- **Reset mid-operation.** Asserting reset clears both stages immediately and drops in-flight results. No response is produced for them.
- **Output stability.** `rsp_*` is stable while `rsp_valid && !rsp_ready`.

## Structure
- Package `fp_arb_pkg` holds:
  - `FP_W=32`, `EXP_W=8`, `MAN_W=23`.
  - The `fp_t` packed struct {sign, exp, man}.
  - The stage record typedef {valid, id, a, b}.
- Sub-module `rr_arbiter` (parameter `N`) takes `req[N]`, `advance` and `clk`/`rst_n`, and outputs one-hot `grant[N]`. It owns the `last_grant` pointer.
- The existing `fp_adder` is instantiated unmodified between S1 and S2.

## Test plan
- **Reset:** with `rst_n=0`, then released with all `req_valid=0`, all outputs read 0 and `req_ready=0`.
- **Single op:** req0 sends `a=0x3FC00000` (1.5) and `b=0x40200000` (2.5) with `rsp_ready=1`. Expect `rsp_valid` 2 cycles later with `rsp_id=0` and `rsp_sum=0x40800000` (4.0).
- **Fairness:** all 4 requesters held valid with `rsp_ready=1`. Grants run 0,1,2,3,0,1 on consecutive cycles. `rsp_id` follows the same order, offset by 2 cycles.
- **Backpressure:** `rsp_ready=0` for 5 cycles with req2 streaming `0x3F800000+0x3F800000`. Exactly 2 accepts, then `req_ready=0`. After release, 2.0 (`0x40000000`) appears in order and no results are lost or duplicated.
- **Cancellation:** req1 sends `a=0xC618CAAE` and `b=0x4618CAAE`, giving `rsp_sum=0x00000000` with `rsp_id=1`.
- **Reset mid-flight:** `rst_n` pulsed low while S1 and S2 are valid. No `rsp_valid` follows, and the next grant goes to req0.
